irq_scheduler: RTL

IRQ_SCHEDULER -- requirements
Module: irq_scheduler

---
 rtl/irq_scheduler.sv | 112 +++++++++++
 1 files changed

// File: rtl/irq_scheduler.sv
// rtl/irq_scheduler.sv - round-robin MSI request scheduler with post-interrupt holdoff
module irq_scheduler #(
  parameter int unsigned HOLDOFF = 250,
  parameter int unsigned NREQ    = 3
) (
  input  logic            trn_clk,
  input  logic            reset,
  input  logic [NREQ-1:0] irq_req,
  output logic [NREQ-1:0] irq_ack,
  output logic            cfg_interrupt_n,
  input  logic            cfg_interrupt_rdy_n,
  input  logic            cfg_interrupt_msienable,
  output logic [31:0]     irq_count
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_HOLD} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     last_grant_q, last_grant_d;
  logic [15:0]       holdoff_q, holdoff_d;
  logic [31:0]       irq_count_q, irq_count_d;
  logic              int_n_q, int_n_d;
  logic [NREQ-1:0]   ack_q, ack_d;

  // Lowest requester strictly above last; if none, lowest requester overall.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [IW-1:0]   last);
    logic [IW-1:0] pick;
    logic          found;
    pick  = last;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (IW'(i) > last)) begin
        pick  = IW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        pick  = IW'(i);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    holdoff_d    = holdoff_q;
    irq_count_d  = irq_count_q;
    int_n_d      = int_n_q;
    ack_d        = '0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_interrupt_msienable && (|irq_req)) begin
          grant_d = rr_pick(irq_req, last_grant_q);
          int_n_d = 1'b0;
          state_d = ST_ASSERT;
        end
      end
      // Once asserted, the handshake completes regardless of req/msienable.
      ST_ASSERT: begin
        if (!cfg_interrupt_rdy_n) begin
          int_n_d         = 1'b1;
          ack_d[grant_q]  = 1'b1;
          last_grant_d    = grant_q;
          irq_count_d     = irq_count_q + 32'd1;
          holdoff_d       = 16'(HOLDOFF);
          state_d         = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (holdoff_q == 16'd0) begin
          state_d = ST_IDLE;
        end else begin
          holdoff_d = holdoff_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(NREQ - 1);
      holdoff_q    <= '0;
      irq_count_q  <= '0;
      int_n_q      <= 1'b1;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      holdoff_q    <= holdoff_d;
      irq_count_q  <= irq_count_d;
      int_n_q      <= int_n_d;
      ack_q        <= ack_d;
    end
  end

  assign irq_ack         = ack_q;
  assign cfg_interrupt_n = int_n_q;
  assign irq_count       = irq_count_q;

endmodule
